// File: rtl/calc_key_sequencer.sv
//------------------------------------------------------------------------------
// Module  : calc_key_sequencer
// Brief   : Debounced push-button front end that latches op/operands, drives
//           the calculator and captures its settled result.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module calc_key_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SETTLE_CYCLES   = 2,
    parameter int CNT_W           = 18
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    output logic [2:0] op_out,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    input  logic [3:0] calc_r,
    input  logic       calc_ovf,
    output logic [3:0] r_hold,
    output logic       ovf_hold,
    output logic       valid,
    output logic       done,
    output logic       busy,
    output logic [7:0] press_cnt
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        ISSUE    = 3'd2,
        CAPTURE  = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       key_meta_q, ks_q;
    logic [2:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       a_q, a_d, b_q, b_d;
    logic [3:0]       r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [2:0]       p;

    // Keys are active-low; p is the pressed vector after synchronization.
    assign p = ~ks_q;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        pcnt_d  = pcnt_q;

        unique case (state_q)
            IDLE: begin
                if (p != 3'b000) begin
                    cand_d  = p;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (p == 3'b000) begin
                    state_d = IDLE;
                end else if (p != cand_q) begin
                    cand_d = p;
                    cnt_d  = '0;
                end else if (cnt_q == DB_LAST) begin
                    op_d    = cand_q;
                    a_d     = SW[7:4];
                    b_d     = SW[3:0];
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ISSUE: begin
                if (cnt_q == SET_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                r_d     = calc_r;
                ovf_d   = calc_ovf;
                valid_d = 1'b1;
                done_d  = 1'b1;
                pcnt_d  = pcnt_q + 8'd1;
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                // Any press restarts the release window so bounces cannot retrigger.
                if (p != 3'b000) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_meta_q <= 3'b111;
            ks_q       <= 3'b111;
            state_q    <= IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            pcnt_q     <= '0;
        end else begin
            key_meta_q <= KEY;
            ks_q       <= key_meta_q;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign op_out    = op_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign r_hold    = r_q;
    assign ovf_hold  = ovf_q;
    assign valid     = valid_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign press_cnt = pcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_key_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_calc_key_sequencer
// Brief   : Directed bench for calc_key_sequencer with an add/subtract model.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_calc_key_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] key;
    logic [7:0] sw;
    logic [2:0] op_out;
    logic [3:0] a_out, b_out;
    logic [3:0] calc_r;
    logic       calc_ovf;
    logic [3:0] r_hold;
    logic       ovf_hold, valid, done, busy;
    logic [7:0] press_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    int done_base  = 0;

    calc_key_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (2),
        .CNT_W          (18)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY      (key),
        .SW       (sw),
        .op_out   (op_out),
        .a_out    (a_out),
        .b_out    (b_out),
        .calc_r   (calc_r),
        .calc_ovf (calc_ovf),
        .r_hold   (r_hold),
        .ovf_hold (ovf_hold),
        .valid    (valid),
        .done     (done),
        .busy     (busy),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculator model: op 001 adds, op 010 subtracts, anything else gives 0.
    always_comb begin
        logic [3:0] t;
        t        = 4'd0;
        calc_ovf = 1'b0;
        case (op_out)
            3'b001: begin
                t        = a_out + b_out;
                calc_ovf = (a_out[3] == b_out[3]) && (t[3] != a_out[3]);
            end
            3'b010: begin
                t        = a_out - b_out;
                calc_ovf = (a_out[3] != b_out[3]) && (t[3] != a_out[3]);
            end
            default: t = 4'd0;
        endcase
        calc_r = t;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset
        rst = 1'b1; key = 3'b111; sw = 8'h00;
        step(3);
        check("rst_op",    {5'd0, op_out}, 8'd0);
        check("rst_ab",    {a_out, b_out}, 8'd0);
        check("rst_r",     {3'd0, valid, r_hold}, 8'd0);
        check("rst_flags", {5'd0, ovf_hold, done, busy}, 8'd0);
        check("rst_pcnt",  press_cnt, 8'd0);
        rst = 1'b0;
        step(5);
        check("post_rst_busy", {7'd0, busy}, 8'd0);
        check("post_rst_all",  {op_out, a_out, valid}, 8'd0);

        // 2. clean add 3+2
        sw = 8'h32; key = 3'b110;
        step(6);
        check("add_pre_latch_op", {5'd0, op_out}, 8'd0);
        check("add_debounce_busy", {7'd0, busy}, 8'd1);
        step(1);
        check("add_latch_op", {5'd0, op_out}, 8'd1);
        check("add_latch_ab", {a_out, b_out}, 8'h32);
        step(3);
        check("add_r",     {4'd0, r_hold}, 8'd5);
        check("add_ovf",   {7'd0, ovf_hold}, 8'd0);
        check("add_valid", {7'd0, valid}, 8'd1);
        check("add_done",  {7'd0, done}, 8'd1);
        check("add_pcnt",  press_cnt, 8'd1);
        step(1);
        check("add_done_low", {7'd0, done}, 8'd0);
        key = 3'b111;
        step(8);
        check("add_idle", {7'd0, busy}, 8'd0);
        check("add_one_done", 8'(done_cnt), 8'd1);

        // 3. overflow 7+1, switches changed during ISSUE
        sw = 8'h71; key = 3'b110;
        step(7);
        check("ovf_latch_ab", {a_out, b_out}, 8'h71);
        sw = 8'h00;
        step(3);
        check("ovf_r",    {4'd0, r_hold}, 8'h08);
        check("ovf_flag", {7'd0, ovf_hold}, 8'd1);
        check("ovf_ab_held", {a_out, b_out}, 8'h71);
        check("ovf_pcnt", press_cnt, 8'd2);
        key = 3'b111;
        step(8);
        check("ovf_idle", {7'd0, busy}, 8'd0);

        // 4. bounce on press, then a stable hold
        done_base = done_cnt;
        sw = 8'h25;
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 3'b110 : 3'b111;
            step(2);
        end
        check("bnc_no_latch", {a_out, b_out}, 8'h71);
        check("bnc_no_done",  8'(done_cnt - done_base), 8'd0);
        key = 3'b110;
        step(7);
        check("bnc_latch_ab", {a_out, b_out}, 8'h25);
        step(3);
        check("bnc_r",    {3'd0, ovf_hold, r_hold}, 8'h07);
        check("bnc_pcnt", press_cnt, 8'd3);
        step(1);
        check("bnc_one_done", 8'(done_cnt - done_base), 8'd1);
        key = 3'b111;
        step(8);

        // 5. subtract 5-3, long hold, bouncy release
        done_base = done_cnt;
        sw = 8'h53; key = 3'b101;
        step(50);
        check("rel_op",   {5'd0, op_out}, 8'd2);
        check("rel_r",    {3'd0, ovf_hold, r_hold}, 8'h02);
        check("rel_pcnt", press_cnt, 8'd4);
        for (int i = 0; i < 10; i++) begin
            key = (i % 2 == 0) ? 3'b111 : 3'b101;
            step(2);
        end
        step(10);
        check("rel_busy_held", {7'd0, busy}, 8'd1);
        check("rel_one_done",  8'(done_cnt - done_base), 8'd1);
        check("rel_pcnt_held", press_cnt, 8'd4);
        key = 3'b111;
        step(8);
        check("rel_idle", {7'd0, busy}, 8'd0);
        check("rel_op_kept", {5'd0, op_out}, 8'd2);
        sw = 8'h11; key = 3'b110;
        step(10);
        check("rel_new_r",    {3'd0, ovf_hold, r_hold}, 8'h02);
        check("rel_new_pcnt", press_cnt, 8'd5);
        step(1);
        key = 3'b111;
        step(8);

        // 6. reset during ISSUE, key held through reset
        done_base = done_cnt;
        sw = 8'h23; key = 3'b110;
        step(8);
        check("mid_busy",  {7'd0, busy}, 8'd1);
        check("mid_latch", {a_out, b_out}, 8'h23);
        rst = 1'b1;
        #1;
        check("mid_clr_ab",   {a_out, b_out}, 8'd0);
        check("mid_clr_misc", {op_out, valid, done, busy, ovf_hold}, 8'd0);
        check("mid_clr_pcnt", press_cnt, 8'd0);
        step(3);
        check("mid_no_done", 8'(done_cnt - done_base), 8'd0);
        rst = 1'b0;
        step(10);
        check("mid_r",     {3'd0, ovf_hold, r_hold}, 8'h05);
        check("mid_valid", {7'd0, valid}, 8'd1);
        check("mid_pcnt",  press_cnt, 8'd1);
        step(1);
        check("mid_one_done", 8'(done_cnt - done_base), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Sequential input-side front end for the combinational 4-bit two's-complement calculator.
- Synchronizes and debounces the active-low push-buttons, then latches the operation code and both switch operands in one step.
- Drives the calculator, waits for its result to settle, and captures the result and overflow flag into held registers for the display path.
- Then requires a debounced full release before it accepts the next press.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a press or release (5 ms at 50 MHz); legal minimum 1.
SETTLE_CYCLES, 2, cycles between operand/op latch and result capture; legal minimum 1.
CNT_W, 18, width of the shared debounce/settle counter; must hold max(DEBOUNCE_CYCLES, SETTLE_CYCLES)-1.

Ports:
CLOCK_50  in   1  system clock, rising edge
RESET     in   1  asynchronous, active-high reset
KEY       in   3  raw push-buttons, active-low, asynchronous to CLOCK_50
SW        in   8  operand switches, A = SW[7:4], B = SW[3:0]
op_out    out  3  latched op vector to calculator (1 = key pressed)
a_out     out  4  latched operand A, two's complement
b_out     out  4  latched operand B, two's complement
calc_r    in   4  calculator result, combinational from op_out/a_out/b_out
calc_ovf  in   1  calculator overflow flag
r_hold    out  4  captured result
ovf_hold  out  1  captured overflow
valid     out  1  high once any result has been captured since reset
done      out  1  one-cycle pulse on each capture
busy      out  1  high in every state other than IDLE
press_cnt out  8  number of completed captures, wraps 255 -> 0

Behaviour:
Interface:
- One clock, CLOCK_50.
- RESET is asynchronous and active-high.
- All state is updated on the rising edge of CLOCK_50.

Synchronizer:
- KEY passes through two flops to produce ks.
- Both flops reset to 3'b111, i.e. all keys released.
- p = ~ks is the pressed vector.

Reset values:
- op_out, a_out, b_out, r_hold, ovf_hold, valid, done, busy and press_cnt all reset to 0.
- State resets to IDLE and the counter resets to 0.

State IDLE:
- If p != 0: set cand <= p, cnt <= 0, go to DEBOUNCE.
- Otherwise stay in IDLE.

State DEBOUNCE:
- If p == 0: return to IDLE.
- Else if p != cand: set cand <= p, cnt <= 0, stay in DEBOUNCE.
- Else if cnt == DEBOUNCE_CYCLES-1: latch op_out <= cand, a_out <= SW[7:4], b_out <= SW[3:0], set cnt <= 0, go to ISSUE.
- Otherwise cnt++.

State ISSUE:
- Holds op_out, a_out and b_out constant.
- When cnt == SETTLE_CYCLES-1, go to CAPTURE; otherwise cnt++.

State CAPTURE (single cycle):
- r_hold <= calc_r, ovf_hold <= calc_ovf, valid <= 1, press_cnt++.
- done is registered, so it is high in the cycle after CAPTURE.
- Then cnt <= 0 and go to RELEASE.

State RELEASE:
- If p != 0: cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1: go to IDLE.
- Otherwise cnt++.

Latency:
- Let edge k be the first edge at which ks shows the press.
- op_out, a_out and b_out update at edge k+1+DEBOUNCE_CYCLES.
- Capture happens at edge k+2+DEBOUNCE_CYCLES+SETTLE_CYCLES.
- done is high for the single cycle after that edge.

Boundary conditions:
- A change on SW or KEY during ISSUE or CAPTURE is ignored; the latched values are used.
- Multiple keys pressed together: the vector is passed through as-is, and any change to it during debounce restarts the count.
- A key held through RESET is seen as a new press once RESET is released, because the synchronizer resets to the released value.
- RESET asserted mid-operation aborts with no done pulse and clears all outputs immediately.
- press_cnt wraps from 255 to 0 with no flag.
- op_out holds its last value while in IDLE; it is not cleared after a capture.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SETTLE_CYCLES=2, with a bench model of the calculator where op 001 = add and op 010 = subtract.
1. Reset: hold RESET with KEY=111 and SW=8'h00 -> all outputs 0 and busy=0; release RESET -> nothing changes.
2. Clean add: SW=8'h32, KEY=110 held -> op_out=001, a_out=3, b_out=2 at edge k+5. Then r_hold=5, ovf_hold=0, a single done pulse, valid=1, press_cnt=1.
3. Overflow: SW=8'h71 (7+1), add -> r_hold=4'b1000, ovf_hold=1. Then SW changed to 8'h00 while in ISSUE -> r_hold is still 8 with ovf_hold=1.
4. Bounce: KEY toggles 110/111 every 2 cycles for 20 cycles, then holds 110 -> no latch during the bounce, and exactly one capture after 4 stable cycles.
5. Release gating: hold the key for 50 cycles, then bounce on release -> no second done pulse. After a clean release and a new press -> press_cnt=2.
6. Reset mid-op: assert RESET while in ISSUE -> outputs cleared with no done pulse. Deassert with the key still held -> a new capture occurs.
